// File: rtl/tail_light_seq.sv
`default_nettype none
// ============================================================================
// Module   : tail_light_seq
// Purpose  : Parametrised rear lamp sequencer with turn fill, hazard flash,
//            brake overlay and PWM-dimmed running lights.
// Revision : 1.0 - initial release
// ============================================================================
module tail_light_seq #(
    parameter int LAMPS      = 3,
    parameter int STEP_DIV   = 4,
    parameter int PWM_PERIOD = 4,
    parameter int DIM_DUTY   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 left,
    input  logic                 right,
    input  logic                 brk,
    input  logic                 hzd,
    input  logic                 rlight,
    output logic [2*LAMPS-1:0]   display
);

    localparam int c_W  = 2 * LAMPS;
    localparam int c_CW = $clog2(LAMPS + 1);
    localparam int c_PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int c_MW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;

    localparam logic [c_PW-1:0] c_PRESC_LAST = c_PW'(STEP_DIV - 1);
    localparam logic [c_CW-1:0] c_CNT_LAST   = c_CW'(LAMPS);
    localparam logic [c_MW-1:0] c_PWM_LAST   = c_MW'(PWM_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TURN_L = 2'd1,
        TURN_R = 2'd2,
        HAZARD = 2'd3
    } mode_t;

    mode_t             r_mode,  w_mode_d;
    logic [c_PW-1:0]   r_presc, w_presc_d;
    logic [c_CW-1:0]   r_cnt,   w_cnt_d;
    logic              r_phase, w_phase_d;
    logic [c_MW-1:0]   r_pwm,   w_pwm_d;
    logic [c_W-1:0]    w_disp_d;

    logic              w_tick;
    logic              w_dim;
    logic [LAMPS-1:0]  w_lpat;
    logic [LAMPS-1:0]  w_rpat;
    logic [LAMPS-1:0]  w_brk_side;
    logic [c_W-1:0]    w_pat;

    always_comb begin
        w_mode_d   = IDLE;
        w_presc_d  = r_presc;
        w_cnt_d    = r_cnt;
        w_phase_d  = r_phase;
        w_pwm_d    = r_pwm;
        w_tick     = (r_presc == c_PRESC_LAST);
        w_dim      = (int'(r_pwm) < DIM_DUTY);
        w_lpat     = '0;
        w_rpat     = '0;
        w_brk_side = brk ? '1 : '0;
        w_pat      = '0;
        w_disp_d   = '0;

        if (hzd || (left && right)) begin
            w_mode_d = HAZARD;
        end else if (left) begin
            w_mode_d = TURN_L;
        end else if (right) begin
            w_mode_d = TURN_R;
        end

        // A mode change restarts the step timing; brake alone never does.
        w_presc_d = w_tick ? '0 : r_presc + c_PW'(1);
        if (w_mode_d != r_mode) begin
            w_presc_d = '0;
            if (w_mode_d == TURN_L || w_mode_d == TURN_R) begin
                w_cnt_d = c_CW'(1);
            end
            if (w_mode_d == HAZARD) begin
                w_phase_d = 1'b1;
            end
        end else if (w_tick) begin
            if (r_mode == TURN_L || r_mode == TURN_R) begin
                w_cnt_d = (r_cnt == c_CNT_LAST) ? '0 : r_cnt + c_CW'(1);
            end
            if (r_mode == HAZARD) begin
                w_phase_d = ~r_phase;
            end
        end

        w_pwm_d = (r_pwm == c_PWM_LAST) ? '0 : r_pwm + c_MW'(1);

        // Left fills upward from its innermost lamp, right fills downward.
        for (int i = 0; i < LAMPS; i++) begin
            w_lpat[i] = (i < int'(r_cnt));
            w_rpat[i] = ((LAMPS - 1 - i) < int'(r_cnt));
        end

        case (r_mode)
            TURN_L:  w_pat = {w_lpat, w_brk_side};
            TURN_R:  w_pat = {w_brk_side, w_rpat};
            HAZARD:  w_pat = (r_phase || brk) ? '1 : '0;
            default: w_pat = brk ? '1 : '0;
        endcase

        w_disp_d = w_pat | {c_W{rlight & w_dim}};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode  <= IDLE;
            r_presc <= '0;
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_pwm   <= '0;
            display <= '0;
        end else begin
            r_mode  <= w_mode_d;
            r_presc <= w_presc_d;
            r_cnt   <= w_cnt_d;
            r_phase <= w_phase_d;
            r_pwm   <= w_pwm_d;
            display <= w_disp_d;
        end
    end

endmodule
`default_nettype wire
